// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared definitions for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, fetch grant, data grant)
//   ram_cmd_t   : one registered RAM command (write enable, lanes, address, data)
//   ZERO_WORD   : all-zero data word used for idle and suppressed outputs
//   SEL_ALL     : all four byte lanes, used for instruction fetches
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL   = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter (instruction fetch, data access) in front
// of one shared single-port RAM.
//   clk, rst                     : clock, synchronous active-high reset
//   if_req/if_addr               : fetch request (read only), held until if_ack
//   if_rdata/if_ack/if_stall     : fetch response and pipeline stall
//   d_req/d_we/d_sel/d_addr/d_wdata : data request, held until d_ack
//   d_rdata/d_ack/d_stall        : data response and pipeline stall
//   ram_ce/we/sel/addr/wdata     : registered RAM command, constant over a grant
//   ram_rdata/ram_ack            : RAM response
//   bus_err                      : pulses with the owner's ack on a timeout
// Data wins simultaneous requests; after a completion the other requester is
// granted directly if it is waiting, so contention alternates D, I, D, I.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        bus_err
);

  // The counter is 0 in the first grant cycle, so it holds WAIT_MAX-1 in the
  // WAIT_MAX-th grant cycle, which is where the access gives up.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  arb_state_t state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       ce_reg, ce_next;
  ram_cmd_t   cmd_reg, cmd_next;

  ram_cmd_t   cmd_fetch, cmd_data;
  logic       granted, timeout, done, entering;

  always_comb begin
    cmd_fetch = '{we: 1'b0, sel: SEL_ALL, addr: if_addr, wdata: ZERO_WORD};
    cmd_data  = '{we: d_we, sel: d_sel, addr: d_addr, wdata: d_wdata};
  end

  // Completion of the current grant, either by the RAM or by the timeout.
  // Qualified with rst so an access cut short by reset never acknowledges.
  always_comb begin
    granted = (state_reg != ST_IDLE);
    timeout = granted && !rst && !ram_ack && (wait_cnt_reg == WAIT_LAST);
    done    = granted && !rst && (ram_ack || timeout);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (d_req)       state_next = ST_GNT_D;
        else if (if_req) state_next = ST_GNT_I;
      end
      ST_GNT_I: if (done) state_next = d_req  ? ST_GNT_D : ST_IDLE;
      ST_GNT_D: if (done) state_next = if_req ? ST_GNT_I : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A new grant starts either from IDLE or directly from a completion
  // (the hand-over to the other requester).
  always_comb begin
    entering      = (state_next != ST_IDLE) && ((state_reg == ST_IDLE) || done);
    wait_cnt_next = wait_cnt_reg;
    ce_next       = ce_reg;
    cmd_next      = cmd_reg;
    if (state_next == ST_IDLE) begin
      wait_cnt_next = '0;
      ce_next       = 1'b0;
      cmd_next      = '0;
    end else if (entering) begin
      wait_cnt_next = '0;
      ce_next       = 1'b1;
      cmd_next      = (state_next == ST_GNT_D) ? cmd_data : cmd_fetch;
    end else begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      ce_reg       <= 1'b0;
      cmd_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ce_reg       <= ce_next;
      cmd_reg      <= cmd_next;
    end
  end

  assign ram_ce    = ce_reg;
  assign ram_we    = cmd_reg.we;
  assign ram_sel   = cmd_reg.sel;
  assign ram_addr  = cmd_reg.addr;
  assign ram_wdata = cmd_reg.wdata;

  // Read data only passes on a genuine RAM ack; a timeout returns zero.
  always_comb begin
    if_ack   = done && (state_reg == ST_GNT_I);
    d_ack    = done && (state_reg == ST_GNT_D);
    if_rdata = (if_ack && ram_ack) ? ram_rdata : ZERO_WORD;
    d_rdata  = (d_ack && ram_ack) ? ram_rdata : ZERO_WORD;
    if_stall = if_req & ~if_ack;
    d_stall  = d_req & ~d_ack;
    bus_err  = timeout;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter kept in the bench.
module tb_mem_arbiter;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack, if_stall;
  logic        d_req, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_stall;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack, bus_err;

  mem_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endfunction

  // ---------------- shared state between processes ----------------
  bit          cmp_en = 1'b0;
  bit          rand_mode = 1'b0;
  bit          seen_ack = 1'b0, seen_if_ack = 1'b0, seen_d_ack = 1'b0, seen_ce = 1'b0;
  int          ram_lat = 0;      // -1: RAM never answers
  int          ram_cnt = 0;
  logic [31:0] ram_fixed = 32'h0;
  int          xact = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- RAM responder ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ram_ce) begin
        if (seen_ack || !seen_ce) begin
          ram_cnt = 0;
          if (rand_mode) begin
            int r;
            r = int'($urandom_range(0, 15));
            ram_lat = (r == 0) ? -1 : (r % 4);
          end
        end else begin
          ram_cnt++;
        end
        ram_ack   = (ram_lat >= 0) && (ram_cnt == ram_lat);
        ram_rdata = rand_mode ? $urandom : ram_fixed;
      end else begin
        ram_cnt   = 0;
        ram_ack   = rand_mode && ($urandom_range(0, 7) == 0);
        ram_rdata = $urandom;
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  // m_owner: 0 nobody, 1 fetch, 2 data. m_k: 1-based cycle count inside a grant.
  int          m_owner = 0;
  int          m_k = 0;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  logic        e_done, e_err, e_if_ack, e_d_ack;

  function automatic void take(int who);
    m_owner = who;
    m_k     = 1;
    if (who == 2) begin
      m_we = d_we; m_sel = d_sel; m_addr = d_addr; m_wdata = d_wdata;
    end else begin
      m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr; m_wdata = 32'h0;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      e_done   = (m_owner != 0) && !rst && (ram_ack || (m_k == WAIT_MAX));
      e_err    = (m_owner != 0) && !rst && !ram_ack && (m_k == WAIT_MAX);
      e_if_ack = e_done && (m_owner == 1);
      e_d_ack  = e_done && (m_owner == 2);
      if (cmp_en) begin
        chk("m_ram_ce",    ram_ce,    32'(m_owner != 0));
        chk("m_ram_we",    ram_we,    (m_owner != 0) ? 32'(m_we) : 32'h0);
        chk("m_ram_sel",   ram_sel,   (m_owner != 0) ? 32'(m_sel) : 32'h0);
        chk("m_ram_addr",  ram_addr,  (m_owner != 0) ? m_addr : 32'h0);
        chk("m_ram_wdata", ram_wdata, (m_owner != 0) ? m_wdata : 32'h0);
        chk("m_if_ack",    if_ack,    32'(e_if_ack));
        chk("m_d_ack",     d_ack,     32'(e_d_ack));
        chk("m_if_rdata",  if_rdata,  (e_if_ack && ram_ack) ? ram_rdata : 32'h0);
        chk("m_d_rdata",   d_rdata,   (e_d_ack && ram_ack) ? ram_rdata : 32'h0);
        chk("m_if_stall",  if_stall,  32'(if_req && !e_if_ack));
        chk("m_d_stall",   d_stall,   32'(d_req && !e_d_ack));
        chk("m_bus_err",   bus_err,   32'(e_err));
      end
      if (if_ack || d_ack) begin
        xact++;
        $display("xact %0d owner=%s addr=%h we=%b sel=%b rdata=%h bus_err=%b",
                 xact, d_ack ? "D" : "I", ram_addr, ram_we, ram_sel,
                 d_ack ? d_rdata : if_rdata, bus_err);
      end
      seen_if_ack = if_ack;
      seen_d_ack  = d_ack;
      seen_ack    = if_ack | d_ack;
      seen_ce     = ram_ce;
      // advance the model to the next cycle
      if (rst) begin
        m_owner = 0;
      end else if (m_owner == 0) begin
        if (d_req)       take(2);
        else if (if_req) take(1);
      end else if (e_done) begin
        if (m_owner == 1 && d_req)       take(2);
        else if (m_owner == 2 && if_req) take(1);
        else                             m_owner = 0;
      end else begin
        m_k++;
      end
    end
  end

  // Waits for an ack (who: 0 fetch, 1 data, 2 either), counting cycles from
  // the current cycle. Leaves the caller at the negedge of the ack cycle.
  task automatic wait_ack(input int who, output int n);
    bit stop;
    logic hit;
    n = 0;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clk);
      hit = (who == 0) ? if_ack : (who == 1) ? d_ack : (if_ack | d_ack);
      if (hit) begin
        stop = 1'b1;
      end else if (n >= 40) begin
        checks++;
        failures++;
        $display("FAIL ack_wait actual=no_ack_after_%0d_cycles required=ack t=%0t", n, $time);
        stop = 1'b1;
      end else begin
        cyc();
        n++;
      end
    end
  endtask

  task automatic idle(int cycles);
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (cycles) cyc();
  endtask

  int n;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_sel = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_ack = 1'b0;

    // ---- reset state ----
    cyc();
    cmp_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_ram_ce", ram_ce, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_d_stall", d_stall, 0);
    cyc();
    rst = 1'b0;
    idle(2);

    // ---- lone fetch, RAM answers one cycle after ce ----
    ram_lat = 1; ram_fixed = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h100;
    wait_ack(0, n);
    chk("fetch_latency", n, 2);
    chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("fetch_we", ram_we, 0);
    chk("fetch_sel", ram_sel, 4'hF);
    cyc();
    idle(3);

    // ---- simultaneous requests: data first, then fetch with no gap ----
    ram_lat = 0; ram_fixed = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    wait_ack(1, n);
    chk("simul_d_first", n, 1);
    chk("simul_we", ram_we, 1);
    chk("simul_wdata", ram_wdata, 32'h1234_5678);
    chk("simul_if_stall", if_stall, 1);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    chk("simul_if_next", if_ack, 1);
    chk("simul_if_addr", ram_addr, 32'h104);
    cyc();
    idle(3);

    // ---- constant contention alternates D, I, D, I ----
    ram_lat = 1;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h400;
    for (int i = 0; i < 8; i++) begin
      wait_ack(2, n);
      chk("alt_d_ack", d_ack, 32'(i % 2 == 0));
      chk("alt_if_ack", if_ack, 32'(i % 2 == 1));
      cyc();
    end
    idle(6);

    // ---- byte store with three wait cycles ----
    ram_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0100; d_addr = 32'h3; d_wdata = 32'hABAB_ABAB;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 1) chk("store_sel", ram_sel, 4'b0100);
      if (c == 4) begin
        chk("store_ack", d_ack, 1);
        chk("store_stall_end", d_stall, 0);
      end else begin
        chk("store_no_ack", d_ack, 0);
        chk("store_stall", d_stall, 1);
        cyc();
      end
    end
    cyc();
    idle(3);

    // ---- timeout: RAM never answers ----
    ram_lat = -1; ram_fixed = 32'hFFFF_FFFF;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h40;
    wait_ack(1, n);
    chk("timeout_cycle", n, WAIT_MAX);
    chk("timeout_err", bus_err, 1);
    chk("timeout_rdata", d_rdata, 0);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    chk("timeout_idle", ram_ce, 0);
    idle(3);

    // ---- reset in the second cycle of a data grant ----
    d_req = 1'b1; d_addr = 32'h80;
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_ack", d_ack, 0);
    cyc();
    rst = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rstmid_ce", ram_ce, 0);
    chk("rstmid_after_ack", d_ack, 0);
    idle(3);

    // ---- randomized traffic ----
    rand_mode = 1'b1;
    repeat (3000) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      if (seen_if_ack || !if_req) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (seen_d_ack || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_sel   = 4'($urandom_range(1, 15));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    cyc();
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles a granted access waits for ram_ack before it is aborted.
REQ-002 Signal list (name, direction, width, meaning), one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- if_req  in  1  instruction-fetch read request, level, held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetch read data, valid with if_ack.
- if_ack  out  1  fetch completion, single-cycle pulse.
- if_stall  out  1  fetch stall request to pipeline control.
- d_req  in  1  data request from memory-access stage, level, held until d_ack.
- d_we  in  1  data write enable.
- d_sel  in  4  data byte lanes.
- d_addr  in  32  data byte address.
- d_wdata  in  32  data write word.
- d_rdata  out  32  data read word, valid with d_ack.
- d_ack  out  1  data completion, single-cycle pulse.
- d_stall  out  1  data stall request to pipeline control.
- ram_ce  out  1  shared RAM chip enable.
- ram_we  out  1  shared RAM write enable.
- ram_sel  out  4  shared RAM byte lanes.
- ram_addr  out  32  shared RAM address.
- ram_wdata  out  32  shared RAM write data.
- ram_rdata  in  32  shared RAM read data, valid with ram_ack.
- ram_ack  in  1  shared RAM completion, single-cycle pulse.
- bus_err  out  1  single-cycle pulse when an access times out.

Function
REQ-003 The FSM SHALL have states IDLE, GNT_I and GNT_D.
REQ-004 In IDLE with d_req high, the FSM SHALL enter GNT_D next cycle; with only if_req high, it SHALL enter GNT_I; data wins on simultaneous requests.
REQ-005 ram_ce, ram_we, ram_sel, ram_addr and ram_wdata SHALL be registered: they are driven from the granted requester's inputs from the first cycle of the grant state and held constant for the whole grant.
REQ-006 In GNT_I, ram_we SHALL be 0 and ram_sel SHALL be 4'b1111.
REQ-007 In IDLE, ram_ce and ram_we SHALL be 0 and ram_sel, ram_addr and ram_wdata SHALL be zero.
REQ-008 When ram_ack is high in a grant state, the arbiter SHALL, in that same cycle, pulse the owner's ack and pass ram_rdata combinationally to the owner's rdata.
REQ-009 The arbiter SHALL ignore ram_ack while in IDLE.
REQ-010 On the ack cycle, the next state SHALL be the other grant state if the other requester's req is high, otherwise IDLE.
- The just-served requester SHALL NOT be re-granted directly, which guarantees alternation under contention.
REQ-011 if_stall SHALL equal if_req & ~if_ack, and d_stall SHALL equal d_req & ~d_ack, both combinational.
REQ-012 if_rdata and d_rdata SHALL be zero when the corresponding ack is low.
REQ-013 A 4-bit wait counter SHALL clear on grant entry and increment each grant cycle without ram_ack.
- When it reaches WAIT_MAX without ram_ack, the arbiter SHALL pulse bus_err and the owner's ack, with rdata forced to zero.
- The FSM SHALL then transition exactly as in REQ-010.
REQ-014 Minimum latency SHALL be 2 cycles from req rising in IDLE to ack: grant register cycle, then a zero-wait RAM ack.

Reset
REQ-015 On rst high at a clock edge, the FSM SHALL enter IDLE, the wait counter SHALL clear, and all registered RAM outputs and bus_err SHALL go to 0.
REQ-016 An in-flight access SHALL be abandoned without issuing an ack.
REQ-017 Combinational outputs SHALL be 0 while in IDLE after reset.

Structure
REQ-018 State encodings and the zero-word constant SHALL live in the shared defines file.
REQ-019 The block SHALL be a single module with no sub-module.

Verification
REQ-020 Lone fetch: if_req=1, if_addr=0x100, RAM acks 1 cycle after ce with 0xDEADBEEF -> if_ack in cycle 2, if_rdata=0xDEADBEEF, ram_we=0, ram_sel=1111.
REQ-021 Simultaneous requests: if_req and d_req (sw, addr 0x200, wdata 0x12345678, sel 1111) -> data granted first with ram_we=1; fetch granted the cycle after d_ack; no idle gap.
REQ-022 Constant contention: both reqs re-asserted after every ack -> grants alternate D, I, D, I across 8 transactions.
REQ-023 Byte store: d_sel=0100, d_wdata=0xABABABAB, addr 0x3 -> ram_sel=0100 held across 3 wait cycles; d_stall=1 until d_ack.
REQ-024 Timeout: WAIT_MAX=15, ram_ack never asserts -> bus_err and d_ack pulse on the 15th grant cycle, d_rdata=0, FSM returns to IDLE.
REQ-025 Reset mid-grant: rst asserted in cycle 2 of GNT_D -> next cycle ram_ce=0, no d_ack, FSM in IDLE.
